// File: rtl/vec_exec_unit.sv
// Execute stage for the vector-extended CPU: opcode decode, a 32-bit scalar ALU and
// four 8-bit lane ALUs, with every output registered for the MEM stage.
module vec_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [4:0]  opcode,
    input  logic        vect,
    input  logic        imm_sel,
    input  logic [7:0]  imm8,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        zero,
    output logic [1:0]  aluop,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        jump
);

    logic [1:0]  w_aluop;
    logic        w_memread, w_memwrite, w_memtoreg, w_regwrite, w_jump;
    logic [31:0] w_opb, w_scalar, w_lanes, w_result;
    logic        w_accept;

    logic        r_valid;
    logic [31:0] r_result;
    logic        r_zero;
    logic [1:0]  r_aluop;
    logic        r_memread, r_memwrite, r_memtoreg, r_regwrite, r_jump;

    always_comb begin
        w_aluop    = 2'b00;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_jump     = 1'b0;
        case (opcode)
            5'h00: w_regwrite = 1'b1;
            5'h01: begin w_aluop = 2'b01; w_regwrite = 1'b1; end
            5'h02: begin w_aluop = 2'b10; w_regwrite = 1'b1; end
            5'h03: begin w_aluop = 2'b11; w_regwrite = 1'b1; end
            5'h04: begin w_memread = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1; end
            5'h05: w_memwrite = 1'b1;
            5'h06: begin w_aluop = 2'b01; w_jump = 1'b1; end
            default: ;
        endcase
    end

    assign w_opb = imm_sel ? {4{imm8}} : b;

    always_comb begin
        w_scalar = 32'h0;
        case (w_aluop)
            2'b00: w_scalar = a + w_opb;
            2'b01: w_scalar = a - w_opb;
            2'b10: w_scalar = a & w_opb;
            2'b11: w_scalar = a | w_opb;
            default: ;
        endcase
    end

    // Each lane is computed on its own 8-bit slice so no carry or borrow leaks across lanes.
    always_comb begin
        w_lanes = 32'h0;
        for (int k = 0; k < 4; k++) begin
            case (w_aluop)
                2'b00: w_lanes[8*k +: 8] = a[8*k +: 8] + w_opb[8*k +: 8];
                2'b01: w_lanes[8*k +: 8] = a[8*k +: 8] - w_opb[8*k +: 8];
                2'b10: w_lanes[8*k +: 8] = a[8*k +: 8] & w_opb[8*k +: 8];
                2'b11: w_lanes[8*k +: 8] = a[8*k +: 8] | w_opb[8*k +: 8];
                default: ;
            endcase
        end
    end

    assign w_result = vect ? w_lanes : w_scalar;
    assign w_accept = in_valid & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= 32'h0;
            r_zero     <= 1'b0;
            r_aluop    <= 2'b00;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_jump     <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_result   <= w_result;
            r_zero     <= (w_scalar == 32'h0);
            r_aluop    <= w_aluop;
            r_memread  <= w_memread;
            r_memwrite <= w_memwrite;
            r_memtoreg <= w_memtoreg;
            r_regwrite <= w_regwrite;
            r_jump     <= w_jump;
        end else begin
            // Bubble or flush: result and zero keep their last captured value.
            r_valid    <= 1'b0;
            r_aluop    <= 2'b00;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_jump     <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign aluop     = r_aluop;
    assign memread   = r_memread;
    assign memwrite  = r_memwrite;
    assign memtoreg  = r_memtoreg;
    assign regwrite  = r_regwrite;
    assign jump      = r_jump;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit: directed cases plus random instructions
// compared against an arithmetic reference model.
module tb_vec_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, vect, imm_sel;
    logic [4:0]  opcode;
    logic [7:0]  imm8;
    logic [31:0] a, b;
    logic        out_valid, zero, memread, memwrite, memtoreg, regwrite, jump;
    logic [31:0] result;
    logic [1:0]  aluop;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: {out_valid, aluop[1:0], memread, memwrite, memtoreg, regwrite, jump}
    logic [7:0]  m_ctrl;
    logic [31:0] m_result;
    logic        m_zero;

    always #5 clk = ~clk;

    vec_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .opcode(opcode), .vect(vect), .imm_sel(imm_sel), .imm8(imm8),
        .a(a), .b(b), .out_valid(out_valid), .result(result), .zero(zero),
        .aluop(aluop), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .jump(jump)
    );

    // Control word for an accepted instruction, valid bit included.
    function automatic logic [7:0] ref_ctrl(input logic [4:0] op);
        case (op)
            5'h00: return 8'b1_00_0001_0;
            5'h01: return 8'b1_01_0001_0;
            5'h02: return 8'b1_10_0001_0;
            5'h03: return 8'b1_11_0001_0;
            5'h04: return 8'b1_00_1011_0;
            5'h05: return 8'b1_00_0100_0;
            5'h06: return 8'b1_01_0000_1;
            default: return 8'b1_00_0000_0;
        endcase
    endfunction

    function automatic longint apply(input int sel, input longint x, input longint y, input longint modulus);
        case (sel)
            0: return (x + y) % modulus;
            1: return (x - y + modulus) % modulus;
            2: return x & y;
            default: return x | y;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " ctrl"}, {24'h0, out_valid, aluop, memread, memwrite, memtoreg, regwrite, jump}, {24'h0, m_ctrl});
        check({tag, " result"}, result, m_result);
        check({tag, " zero"}, {31'h0, zero}, {31'h0, m_zero});
    endtask

    task automatic step(input string tag, input logic v, input logic cl, input logic [4:0] op,
                        input logic vc, input logic is, input logic [7:0] im,
                        input logic [31:0] aa, input logic [31:0] bb);
        logic [31:0] opb, scal, lanes;
        int sel;
        @(negedge clk);
        in_valid = v; clear = cl; opcode = op; vect = vc; imm_sel = is; imm8 = im; a = aa; b = bb;
        @(posedge clk);
        #1;
        if (v && !cl) begin
            m_ctrl = ref_ctrl(op);
            sel    = int'(m_ctrl[6:5]);
            opb    = is ? {im, im, im, im} : bb;
            scal   = 32'(apply(sel, longint'(aa), longint'(opb), 64'h1_0000_0000));
            for (int k = 0; k < 4; k++)
                lanes[8*k +: 8] = 8'(apply(sel, longint'(aa[8*k +: 8]), longint'(opb[8*k +: 8]), 256));
            m_result = vc ? lanes : scal;
            m_zero   = (scal == 0);
        end else begin
            m_ctrl = 8'h00;
        end
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; opcode = 5'h00; vect = 1'b0;
        imm_sel = 1'b0; imm8 = 8'h00; a = 32'h1; b = 32'h1;
        m_ctrl = 8'h00; m_result = 32'h0; m_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("reset_hold");
        @(negedge clk) rst_n = 1'b1;
        #1 check_all("reset_release_no_edge");

        step("first_add",    1, 0, 5'h00, 0, 0, 8'h00, 32'h0000_0005, 32'h0000_0003);
        step("scalar_add",   1, 0, 5'h00, 0, 0, 8'h00, 32'h01FF_7F80, 32'h0101_0101);
        check("scalar_add_lit", result, 32'h0300_8081);
        step("vector_add",   1, 0, 5'h00, 1, 0, 8'h00, 32'h01FF_7F80, 32'h0101_0101);
        check("vector_add_lit", result, 32'h0200_8081);
        step("vector_sub",   1, 0, 5'h01, 1, 0, 8'h00, 32'h0000_0000, 32'h0101_0101);
        check("vector_sub_lit", result, 32'hFFFF_FFFF);
        step("jmp",          1, 0, 5'h06, 1, 0, 8'h00, 32'h1234_5678, 32'h1234_5678);
        check("jmp_zero_lit", {31'h0, zero}, 32'h1);
        step("imm_and",      1, 0, 5'h02, 0, 1, 8'h0F, 32'h1234_5678, 32'hFFFF_FFFF);
        check("imm_and_lit", result, 32'h0204_0608);
        step("ldr",          1, 0, 5'h04, 0, 1, 8'h04, 32'h0000_0100, 32'h0);
        step("str",          1, 0, 5'h05, 0, 0, 8'h00, 32'h0000_0200, 32'h0000_0010);
        step("clear_wins",   1, 1, 5'h00, 0, 0, 8'h00, 32'hDEAD_BEEF, 32'h1);
        step("bubble",       0, 0, 5'h01, 0, 0, 8'h00, 32'h5555_5555, 32'h1);
        step("nop_1f",       1, 0, 5'h1F, 0, 0, 8'h00, 32'h0000_0001, 32'h0000_0002);
        step("nop_07",       1, 0, 5'h07, 1, 0, 8'h00, 32'hFFFF_FFFF, 32'h0000_0001);
        step("orr_vec",      1, 0, 5'h03, 1, 1, 8'hA0, 32'h0102_0304, 32'h0);

        // Reset mid-stream must clear outputs without waiting for a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_ctrl = 8'h00; m_result = 32'h0; m_zero = 1'b0;
        #1 check_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        step("after_reset",  1, 0, 5'h01, 0, 0, 8'h00, 32'h0000_0010, 32'h0000_0011);

        for (int i = 0; i < 300; i++) begin
            step("random",
                 ($urandom_range(3) != 0), ($urandom_range(7) == 0),
                 5'($urandom_range(31)), 1'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(7) == 0) ? 32'h0 : $urandom, $urandom);
        end
        step("random_sub_eq", 1, 0, 5'h01, 0, 0, 8'h00, 32'h7777_0001, 32'h7777_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
